commit_trace_checker: RTL and testbench

//  Synthesizable retirement checker for the multi-cycle/superscalar CPU; sits beside the cpu on debug commit ports.

---
 rtl/commit_trace_checker.sv | 169 ++++++++++++++++
 tb/tb_commit_trace_checker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/commit_trace_checker.sv
// Retirement checker: compacts up to NCH retired instructions per cycle into a FIFO and
// compares them in order against an expected trace, latching the first mismatch.

module commit_trace_lane #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int PTR_W = 3
) (
  input  logic [AW-1:0]         pc,
  input  logic [31:0]           instr,
  input  logic                  rd_we,
  input  logic [4:0]            rd,
  input  logic [DW-1:0]         rd_data,
  input  logic [PTR_W-1:0]      base,
  input  logic [PTR_W-1:0]      off,
  output logic [AW+38+DW-1:0]   rec,
  output logic [PTR_W-1:0]      idx
);
  assign rec = {pc, instr, rd_we, rd, rd_data};
  // Power-of-two depth, so the natural pointer wrap is the FIFO wrap.
  assign idx = base + off;
endmodule

module commit_trace_checker #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          NCH         = 2,
  parameter int          FIFO_DEPTH  = 8,
  parameter int unsigned STOP_PC     = 88,
  parameter int          CNT_WIDTH   = 32,
  parameter bit          HALT_ON_ERR = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NCH-1:0]              commit_valid_i,
  input  logic [NCH*ADDR_WIDTH-1:0]   commit_pc_i,
  input  logic [NCH*32-1:0]           commit_instr_i,
  input  logic [NCH-1:0]              commit_rd_we_i,
  input  logic [NCH*5-1:0]            commit_rd_i,
  input  logic [NCH*DATA_WIDTH-1:0]   commit_rd_data_i,
  output logic                        commit_ready_o,
  input  logic                        exp_valid_i,
  output logic                        exp_ready_o,
  input  logic [ADDR_WIDTH-1:0]       exp_pc_i,
  input  logic [31:0]                 exp_instr_i,
  input  logic                        exp_rd_we_i,
  input  logic [4:0]                  exp_rd_i,
  input  logic [DATA_WIDTH-1:0]       exp_rd_data_i,
  output logic                        err_o,
  output logic [3:0]                  err_field_o,
  output logic [CNT_WIDTH-1:0]        err_idx_o,
  output logic [ADDR_WIDTH-1:0]       err_pc_o,
  output logic                        overflow_o,
  output logic                        done_o,
  output logic [CNT_WIDTH-1:0]        instr_count_o,
  output logic [CNT_WIDTH-1:0]        cycle_count_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REC_W = ADDR_WIDTH + 38 + DATA_WIDTH;
  localparam logic [PTR_W:0] READY_LIM = (PTR_W+1)'(FIFO_DEPTH - NCH);

  typedef enum logic [1:0] {RUN, HALT, DONE} state_t;

  state_t                         state;
  logic [REC_W-1:0]               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]               wr_ptr, rd_ptr;
  logic [PTR_W:0]                 count, n_push;
  logic [NCH-1:0][PTR_W-1:0]      lane_off, lane_idx;
  logic [NCH-1:0][REC_W-1:0]      lane_rec;
  logic                           push_en, pop, mism_seen;

  logic [ADDR_WIDTH-1:0]          h_pc;
  logic [31:0]                    h_instr;
  logic                           h_we;
  logic [4:0]                     h_rd;
  logic [DATA_WIDTH-1:0]          h_data;
  logic [3:0]                     field;

  // Prefix count of valid lanes gives each lane its compacted slot.
  always_comb begin
    n_push = '0;
    for (int k = 0; k < NCH; k++) begin
      lane_off[k] = n_push[PTR_W-1:0];
      n_push      = n_push + (PTR_W+1)'(commit_valid_i[k]);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    commit_trace_lane #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .PTR_W(PTR_W)) u_lane (
      .pc      (commit_pc_i[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .instr   (commit_instr_i[k*32 +: 32]),
      .rd_we   (commit_rd_we_i[k]),
      .rd      (commit_rd_i[k*5 +: 5]),
      .rd_data (commit_rd_data_i[k*DATA_WIDTH +: DATA_WIDTH]),
      .base    (wr_ptr),
      .off     (lane_off[k]),
      .rec     (lane_rec[k]),
      .idx     (lane_idx[k])
    );
  end

  // Ready keeps more than one full commit group of headroom.
  assign commit_ready_o = (state == DONE) || (count < READY_LIM);
  assign push_en        = commit_ready_o && (state != DONE);
  assign exp_ready_o    = (state == RUN) && (count != '0);
  assign pop            = exp_valid_i && exp_ready_o;

  assign {h_pc, h_instr, h_we, h_rd, h_data} = mem[rd_ptr];

  always_comb begin
    field    = '0;
    field[0] = h_pc != exp_pc_i;
    field[1] = h_instr != exp_instr_i;
    field[2] = (h_we != exp_rd_we_i) ||
               (h_we && exp_rd_we_i && h_rd != 5'd0 && h_rd != exp_rd_i);
    field[3] = h_we && exp_rd_we_i && h_rd != 5'd0 && h_data != exp_rd_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (push_en)
      for (int k = 0; k < NCH; k++)
        if (commit_valid_i[k]) mem[lane_idx[k]] <= lane_rec[k];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_o         <= 1'b0;
      err_field_o   <= '0;
      err_idx_o     <= '0;
      err_pc_o      <= '0;
      overflow_o    <= 1'b0;
      done_o        <= 1'b0;
      mism_seen     <= 1'b0;
      instr_count_o <= '0;
      cycle_count_o <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + n_push[PTR_W-1:0];
      count <= count + (push_en ? n_push : '0) - (PTR_W+1)'(pop);
      if (|commit_valid_i && !commit_ready_o) begin
        overflow_o <= 1'b1;
        err_o      <= 1'b1;
      end
      if (state == RUN && cycle_count_o != '1) cycle_count_o <= cycle_count_o + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (instr_count_o != '1) instr_count_o <= instr_count_o + 1'b1;
        if (|field) begin
          err_o     <= 1'b1;
          mism_seen <= 1'b1;
          if (!mism_seen) begin
            err_field_o <= field;
            err_idx_o   <= instr_count_o;
            err_pc_o    <= h_pc;
          end
        end
        if (h_pc == ADDR_WIDTH'(STOP_PC)) begin
          state  <= DONE;
          done_o <= 1'b1;
        end else if (|field && HALT_ON_ERR) begin
          state <= HALT;
        end
      end
    end
  end
endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker (NCH=2, depth 8, STOP_PC=88, halt on error).

module tb_commit_trace_checker;
  localparam int AW = 32, DW = 32, NCH = 2, CW = 32;

  logic                 clk_i = 1'b0, rst_i = 1'b1;
  logic [NCH-1:0]       commit_valid_i = '0;
  logic [NCH*AW-1:0]    commit_pc_i = '0;
  logic [NCH*32-1:0]    commit_instr_i = '0;
  logic [NCH-1:0]       commit_rd_we_i = '0;
  logic [NCH*5-1:0]     commit_rd_i = '0;
  logic [NCH*DW-1:0]    commit_rd_data_i = '0;
  logic                 commit_ready_o, exp_ready_o;
  logic                 exp_valid_i = 1'b0;
  logic [AW-1:0]        exp_pc_i = '0;
  logic [31:0]          exp_instr_i = '0;
  logic                 exp_rd_we_i = 1'b0;
  logic [4:0]           exp_rd_i = '0;
  logic [DW-1:0]        exp_rd_data_i = '0;
  logic                 err_o, overflow_o, done_o;
  logic [3:0]           err_field_o;
  logic [CW-1:0]        err_idx_o, instr_count_o, cycle_count_o, cyc_snap;
  logic [AW-1:0]        err_pc_o;
  int                   n_tests = 0, n_fail = 0;

  commit_trace_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NCH(NCH), .FIFO_DEPTH(8),
    .STOP_PC(88), .CNT_WIDTH(CW), .HALT_ON_ERR(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
    .commit_instr_i(commit_instr_i), .commit_rd_we_i(commit_rd_we_i), .commit_rd_i(commit_rd_i),
    .commit_rd_data_i(commit_rd_data_i), .commit_ready_o(commit_ready_o),
    .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o), .exp_pc_i(exp_pc_i),
    .exp_instr_i(exp_instr_i), .exp_rd_we_i(exp_rd_we_i), .exp_rd_i(exp_rd_i),
    .exp_rd_data_i(exp_rd_data_i), .err_o(err_o), .err_field_o(err_field_o),
    .err_idx_o(err_idx_o), .err_pc_o(err_pc_o), .overflow_o(overflow_o), .done_o(done_o),
    .instr_count_o(instr_count_o), .cycle_count_o(cycle_count_o));

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; commit_valid_i = '0; exp_valid_i = 1'b0;
    step();
    rst_i = 1'b0;
  endtask

  task automatic lane(input int k, input logic [31:0] pc, input logic we,
                      input logic [4:0] rd, input logic [31:0] data);
    commit_valid_i[k]          = 1'b1;
    commit_pc_i[k*AW +: AW]    = pc;
    commit_instr_i[k*32 +: 32] = 32'h13 + pc;
    commit_rd_we_i[k]          = we;
    commit_rd_i[k*5 +: 5]      = rd;
    commit_rd_data_i[k*DW +: DW] = data;
  endtask

  task automatic expect_rec(input logic [31:0] pc, input logic we,
                            input logic [4:0] rd, input logic [31:0] data);
    exp_valid_i = 1'b1; exp_pc_i = pc; exp_instr_i = 32'h13 + pc;
    exp_rd_we_i = we; exp_rd_i = rd; exp_rd_data_i = data;
  endtask

  initial begin
    // Reset state and cycle counter start
    do_reset();
    check("rst_commit_ready", commit_ready_o, 1);
    check("rst_exp_ready", exp_ready_o, 0);
    check("rst_err", {err_o, overflow_o, done_o, err_field_o}, 0);
    check("rst_icount", instr_count_o, 0);
    step(); step(); step();
    check("cycle_count_3", cycle_count_o, 3);

    // 1) two lanes then two matching records
    do_reset();
    lane(0, 0, 1, 1, 10); lane(1, 4, 1, 2, 20);
    step(); commit_valid_i = '0;
    check("t1_exp_ready_a", exp_ready_o, 1);
    expect_rec(0, 1, 1, 10); step();
    check("t1_icount_1", instr_count_o, 1);
    check("t1_exp_ready_b", exp_ready_o, 1);
    expect_rec(4, 1, 2, 20); step(); exp_valid_i = 1'b0;
    check("t1_icount_2", instr_count_o, 2);
    check("t1_err", err_o, 0);
    check("t1_empty", exp_ready_o, 0);

    // 2) sparse lane 1 lands at head; data mismatch halts
    do_reset();
    lane(1, 8, 1, 3, 6);
    step(); commit_valid_i = '0;
    expect_rec(8, 1, 3, 5); step(); exp_valid_i = 1'b0;
    check("t2_err", err_o, 1);
    check("t2_field", err_field_o, 4'b1000);
    check("t2_idx", err_idx_o, 0);
    check("t2_pc", err_pc_o, 8);
    lane(0, 12, 0, 0, 0); step(); commit_valid_i = '0;
    expect_rec(12, 0, 0, 0); step();
    check("t2_halt_no_ready", exp_ready_o, 0);
    check("t2_halt_icount", instr_count_o, 1);
    exp_valid_i = 1'b0;

    // 3) x0 writes ignored; rd_we mismatch flagged
    do_reset();
    lane(0, 12, 1, 0, 7); step(); commit_valid_i = '0;
    expect_rec(12, 1, 0, 9); step(); exp_valid_i = 1'b0;
    check("t3_x0_err", err_o, 0);
    lane(0, 16, 1, 4, 1); step(); commit_valid_i = '0;
    expect_rec(16, 0, 4, 1); step(); exp_valid_i = 1'b0;
    check("t3_field", err_field_o, 4'b0100);
    check("t3_idx", err_idx_o, 1);
    check("t3_pc", err_pc_o, 16);

    // 4) fill to 6, then overflow drops the whole group
    do_reset();
    for (int c = 0; c < 3; c++) begin
      lane(0, 100 + 8*c, 0, 0, 0); lane(1, 104 + 8*c, 0, 0, 0);
      step();
      check($sformatf("t4_ready_%0d", c), commit_ready_o, (c < 2) ? 1 : 0);
    end
    check("t4_no_ovf_yet", overflow_o, 0);
    lane(0, 124, 0, 0, 0); lane(1, 128, 0, 0, 0);
    step(); commit_valid_i = '0;
    check("t4_overflow", {overflow_o, err_o}, 2'b11);
    check("t4_field_zero", err_field_o, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t4_drain_%0d", i), exp_ready_o, 1);
      expect_rec(100 + 4*i, 0, 0, 0); step();
    end
    exp_valid_i = 1'b0;
    check("t4_count6", exp_ready_o, 0);
    check("t4_icount", instr_count_o, 6);
    check("t4_field_still_zero", err_field_o, 0);

    // 5) STOP_PC ends the run
    do_reset();
    lane(0, 80, 0, 0, 0); lane(1, 84, 0, 0, 0); step();
    commit_valid_i = '0; lane(0, 88, 0, 0, 0); step(); commit_valid_i = '0;
    expect_rec(80, 0, 0, 0); step();
    expect_rec(84, 0, 0, 0); step();
    check("t5_not_done", done_o, 0);
    expect_rec(88, 0, 0, 0); step(); exp_valid_i = 1'b0;
    check("t5_done", done_o, 1);
    check("t5_icount", instr_count_o, 3);
    check("t5_err", err_o, 0);
    cyc_snap = cycle_count_o;
    lane(0, 92, 0, 0, 0); lane(1, 96, 0, 0, 0); step(); step(); commit_valid_i = '0;
    check("t5_cyc_frozen", cycle_count_o, cyc_snap);
    check("t5_no_ovf", overflow_o, 0);
    check("t5_ready", {commit_ready_o, exp_ready_o}, 2'b10);

    // 6) async reset mid-run with 3 entries and err set
    do_reset();
    lane(0, 0, 1, 2, 3); step(); commit_valid_i = '0;
    expect_rec(0, 1, 2, 4); step(); exp_valid_i = 1'b0;
    lane(0, 4, 0, 0, 0); lane(1, 8, 0, 0, 0); step();
    commit_valid_i = '0; lane(0, 12, 0, 0, 0); step(); commit_valid_i = '0;
    check("t6_pre_err", err_o, 1);
    #2 rst_i = 1'b1; #1;
    check("t6_async_clr", {err_o, err_field_o, overflow_o, done_o, exp_ready_o, commit_ready_o}, 9'b1);
    check("t6_async_cnt", instr_count_o, 0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    check("t6_empty", exp_ready_o, 0);
    lane(0, 20, 1, 5, 55); step(); commit_valid_i = '0;
    expect_rec(20, 1, 5, 55); step(); exp_valid_i = 1'b0;
    check("t6_resume", {err_o, instr_count_o}, {1'b0, 32'd1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
